// File: rtl/ps2_device_tx.sv
// PS/2 device-side endpoint: keyboard end of a PS/2 link.
// Drives the PS/2 clock, sends bytes to the host and receives host commands.
//
// Ports:
//   clock, reset_n        single clock, synchronous active-low reset
//   tx_data/valid/ready   byte stream to send to the host (valid/ready)
//   rx_data/valid/error   host command byte, one-cycle valid/error pulses
//   busy                  a tx or rx frame (or inhibit wait) is in progress
//   ps2_clock_in/ps2_data raw open-collector line levels (asynchronous)
//   ps2_clock_out/data_out 0 pulls the line low, 1 releases it
module ps2_device_tx #(
    parameter int unsigned HALF_BIT    = 2000,
    parameter int unsigned IDLE_CYCLES = 2500,
    parameter bit          AUTO_ACK    = 1'b1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_error,
    output logic       busy,
    input  logic       ps2_clock_in,
    input  logic       ps2_data,
    output logic       ps2_clock_out,
    output logic       ps2_data_out
);

    typedef enum logic [2:0] {
        IDLE,
        TX_HIGH,
        TX_LOW,
        RX_HIGH,
        RX_LOW,
        RX_ACK,
        INHIBIT
    } state_t;

    localparam logic [7:0] REPLY_ACK    = 8'hFA;
    localparam logic [7:0] REPLY_RESEND = 8'hFE;

    state_t      state;
    logic        clk_meta;
    logic        clk_s;
    logic        dat_meta;
    logic        dat_s;
    logic [31:0] phase_cnt;
    logic [31:0] idle_cnt;
    logic [3:0]  bit_cnt;
    logic [2:0]  blank_cnt;
    logic        ack_low;
    logic        user_full;
    logic [7:0]  user_byte;
    logic        auto_full;
    logic [7:0]  auto_byte;
    logic        cur_auto;
    logic [10:0] tx_frame;
    logic [10:0] rx_bits;

    logic        phase_end;
    logic        idle_ok;
    logic        inhibit;
    logic        rx_good;
    logic [7:0]  pend_byte;
    logic [10:0] next_frame;

    function automatic logic [10:0] make_frame(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    // Two-flop synchronizers for the raw line levels.
    always_ff @(posedge clock) begin
        clk_meta <= ps2_clock_in;
        clk_s    <= clk_meta;
        dat_meta <= ps2_data;
        dat_s    <= dat_meta;
    end

    assign phase_end  = (phase_cnt == HALF_BIT - 1);
    assign idle_ok    = (idle_cnt >= IDLE_CYCLES);
    assign pend_byte  = auto_full ? auto_byte : user_byte;
    assign next_frame = make_frame(pend_byte);
    assign tx_ready   = ~user_full;

    // Host holds the clock low while we release it; blank_cnt hides the
    // synchronizer lag right after our own release.
    assign inhibit = (state != IDLE) && (state != INHIBIT) &&
                     ps2_clock_out && (blank_cnt == 3'd0) && !clk_s;

    // Start 0, stop 1, and odd parity across data plus parity bit.
    assign rx_good = !rx_bits[0] && rx_bits[10] && (^rx_bits[9:1]);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= IDLE;
            phase_cnt     <= '0;
            idle_cnt      <= '0;
            bit_cnt       <= '0;
            blank_cnt     <= '0;
            ack_low       <= 1'b0;
            user_full     <= 1'b0;
            user_byte     <= '0;
            auto_full     <= 1'b0;
            auto_byte     <= '0;
            cur_auto      <= 1'b0;
            tx_frame      <= '1;
            rx_bits       <= '0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_error      <= 1'b0;
            busy          <= 1'b0;
            ps2_clock_out <= 1'b1;
            ps2_data_out  <= 1'b1;
        end else begin
            rx_valid <= 1'b0;
            rx_error <= 1'b0;

            if (tx_valid && !user_full) begin
                user_full <= 1'b1;
                user_byte <= tx_data;
            end

            if (blank_cnt != 3'd0) begin
                blank_cnt <= blank_cnt - 3'd1;
            end

            phase_cnt <= phase_end ? '0 : phase_cnt + 32'd1;

            // Idle time keeps accumulating through INHIBIT so a retained
            // frame restarts as soon as the bus has been quiet long enough.
            unique case (state)
                IDLE: begin
                    if (clk_s && dat_s) begin
                        idle_cnt <= idle_ok ? idle_cnt : idle_cnt + 32'd1;
                    end else begin
                        idle_cnt <= '0;
                    end
                end
                INHIBIT: begin
                    if (clk_s) begin
                        idle_cnt <= idle_ok ? idle_cnt : idle_cnt + 32'd1;
                    end else begin
                        idle_cnt <= '0;
                    end
                end
                default: idle_cnt <= '0;
            endcase

            if (inhibit) begin
                // Pending bytes are only cleared on completion, so an
                // aborted tx frame is resent whole; rx is dropped silently.
                state         <= INHIBIT;
                phase_cnt     <= '0;
                ack_low       <= 1'b0;
                busy          <= 1'b1;
                ps2_clock_out <= 1'b1;
                ps2_data_out  <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        phase_cnt <= '0;
                        if (clk_s && !dat_s) begin
                            state         <= RX_HIGH;
                            bit_cnt       <= '0;
                            blank_cnt     <= 3'd4;
                            busy          <= 1'b1;
                            ps2_clock_out <= 1'b1;
                            ps2_data_out  <= 1'b1;
                        end else if ((auto_full || user_full) &&
                                     idle_ok && clk_s && dat_s) begin
                            state         <= TX_HIGH;
                            tx_frame      <= next_frame;
                            cur_auto      <= auto_full;
                            bit_cnt       <= '0;
                            blank_cnt     <= 3'd4;
                            busy          <= 1'b1;
                            ps2_clock_out <= 1'b1;
                            ps2_data_out  <= 1'b0;
                        end
                    end

                    TX_HIGH: begin
                        if (phase_end) begin
                            state         <= TX_LOW;
                            ps2_clock_out <= 1'b0;
                        end
                    end

                    TX_LOW: begin
                        if (phase_end) begin
                            ps2_clock_out <= 1'b1;
                            if (bit_cnt == 4'd10) begin
                                state        <= IDLE;
                                busy         <= 1'b0;
                                ps2_data_out <= 1'b1;
                                if (cur_auto) begin
                                    auto_full <= 1'b0;
                                end else begin
                                    user_full <= 1'b0;
                                end
                            end else begin
                                state        <= TX_HIGH;
                                bit_cnt      <= bit_cnt + 4'd1;
                                blank_cnt    <= 3'd4;
                                ps2_data_out <= tx_frame[bit_cnt + 4'd1];
                            end
                        end
                    end

                    RX_HIGH: begin
                        if (phase_end) begin
                            rx_bits[bit_cnt] <= dat_s;
                            state            <= RX_LOW;
                            ps2_clock_out    <= 1'b0;
                        end
                    end

                    RX_LOW: begin
                        if (phase_end) begin
                            ps2_clock_out <= 1'b1;
                            blank_cnt     <= 3'd4;
                            if (bit_cnt != 4'd10) begin
                                state   <= RX_HIGH;
                                bit_cnt <= bit_cnt + 4'd1;
                            end else if (rx_good) begin
                                state        <= RX_ACK;
                                ack_low      <= 1'b0;
                                ps2_data_out <= 1'b0;
                            end else begin
                                state    <= IDLE;
                                busy     <= 1'b0;
                                rx_error <= 1'b1;
                                if (AUTO_ACK) begin
                                    auto_full <= 1'b1;
                                    auto_byte <= REPLY_RESEND;
                                end
                            end
                        end
                    end

                    RX_ACK: begin
                        if (phase_end) begin
                            if (!ack_low) begin
                                ack_low       <= 1'b1;
                                ps2_clock_out <= 1'b0;
                            end else begin
                                state         <= IDLE;
                                ack_low       <= 1'b0;
                                busy          <= 1'b0;
                                ps2_clock_out <= 1'b1;
                                ps2_data_out  <= 1'b1;
                                rx_valid      <= 1'b1;
                                rx_data       <= rx_bits[8:1];
                                if (AUTO_ACK) begin
                                    auto_full <= 1'b1;
                                    auto_byte <= REPLY_ACK;
                                end
                            end
                        end
                    end

                    INHIBIT: begin
                        phase_cnt <= '0;
                        if (idle_ok) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end

                    default: begin
                        state         <= IDLE;
                        busy          <= 1'b0;
                        ps2_clock_out <= 1'b1;
                        ps2_data_out  <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Directed bench for ps2_device_tx with an open-collector host model.
// Frames are captured at device clock falling edges and checked bit by bit.
module tb_ps2_device_tx;

    localparam int HB  = 20;
    localparam int IC  = 50;
    localparam int LIM = 3000;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_error;
    logic       busy;
    logic       ps2_clock_in;
    logic       ps2_data;
    logic       ps2_clock_out;
    logic       ps2_data_out;
    logic       host_clk = 1'b1;
    logic       host_dat = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;
    int n_rxv = 0;
    int n_rxe = 0;

    assign ps2_clock_in = ps2_clock_out & host_clk;
    assign ps2_data     = ps2_data_out & host_dat;

    ps2_device_tx #(
        .HALF_BIT   (HB),
        .IDLE_CYCLES(IC),
        .AUTO_ACK   (1'b1)
    ) dut (
        .clock        (clk),
        .reset_n      (reset_n),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_error     (rx_error),
        .busy         (busy),
        .ps2_clock_in (ps2_clock_in),
        .ps2_data     (ps2_data),
        .ps2_clock_out(ps2_clock_out),
        .ps2_data_out (ps2_data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rx_valid) n_rxv <= n_rxv + 1;
        if (rx_error) n_rxe <= n_rxe + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_fall(output int n, output bit ok);
        n = 0;
        while (ps2_clock_out !== 1'b1 && n < LIM) begin
            @(negedge clk);
            n++;
        end
        while (ps2_clock_out === 1'b1 && n < LIM) begin
            @(negedge clk);
            n++;
        end
        ok = (n < LIM) && (ps2_clock_out === 1'b0);
    endtask

    task automatic get_frame(output logic [10:0] bits, output int gap,
                             output int lmin, output int lmax,
                             output bit ok);
        int n;
        int len;
        bit f;
        bits = '0;
        gap  = 0;
        lmin = LIM;
        lmax = 0;
        ok   = 1'b1;
        for (int i = 0; i < 11; i++) begin
            wait_fall(n, f);
            if (!f) begin
                ok = 1'b0;
                return;
            end
            if (i == 0) gap = n;
            bits[i] = ps2_data_out;
            len = 0;
            while (ps2_clock_out === 1'b0 && len < LIM) begin
                len++;
                @(negedge clk);
            end
            if (len < lmin) lmin = len;
            if (len > lmax) lmax = len;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic host_send(input logic [7:0] b, input logic par,
                             output bit ok);
        logic [10:0] f;
        int n;
        bit g;
        f  = {1'b1, par, b, 1'b0};
        ok = 1'b1;
        @(negedge clk);
        host_dat = 1'b0;
        for (int i = 0; i < 11; i++) begin
            wait_fall(n, g);
            if (!g) begin
                ok = 1'b0;
                host_dat = 1'b1;
                return;
            end
            host_dat = (i < 10) ? f[i + 1] : 1'b1;
        end
    endtask

    initial begin
        logic [10:0] bits;
        int gap;
        int lmin;
        int lmax;
        int n;
        int k;
        int v0;
        int e0;
        int lows;
        bit ok;
        bit f;
        bit seen;

        repeat (3) @(negedge clk);
        chk("rst_clk", ps2_clock_out, 1);
        chk("rst_dat", ps2_data_out, 1);
        chk("rst_ready", tx_ready, 1);
        chk("rst_rxdata", rx_data, 8'h00);
        chk("rst_rxv", rx_valid, 0);
        chk("rst_rxe", rx_error, 0);
        chk("rst_busy", busy, 0);
        reset_n = 1'b1;

        // Plain 0x1C frame.
        send_byte(8'h1C);
        get_frame(bits, gap, lmin, lmax, ok);
        chk("t1_done", ok, 1);
        chk("t1_bits", bits, 11'b10000111000);
        chk("t1_lowmin", lmin, HB);
        chk("t1_lowmax", lmax, HB);

        // Inhibit during a data bit that drives the line low.
        send_byte(8'h1C);
        for (int i = 0; i < 6; i++) wait_fall(n, f);
        chk("inh_reach", f, 1);
        k = 0;
        while (ps2_clock_out === 1'b0 && k < LIM) begin
            @(negedge clk);
            k++;
        end
        repeat (5) @(negedge clk);
        chk("inh_pre", ps2_data_out, 0);
        host_clk = 1'b0;
        k = 0;
        while (!(ps2_clock_out && ps2_data_out) && k < 3) begin
            @(negedge clk);
            k++;
        end
        chk("inh_resp", ps2_clock_out && ps2_data_out, 1);
        repeat (30) @(negedge clk);
        chk("inh_ready", tx_ready, 0);
        chk("inh_busy", busy, 1);
        host_clk = 1'b1;
        get_frame(bits, gap, lmin, lmax, ok);
        chk("inh_done", ok, 1);
        chk("inh_bits", bits, 11'b10000111000);
        chk("inh_gap", gap >= IC + HB, 1);
        chk("inh_ready2", tx_ready, 1);

        // Good host command 0xED -> ACK bit, rx_valid, reply 0xFA.
        v0 = n_rxv;
        e0 = n_rxe;
        host_send(8'hED, 1'b1, ok);
        chk("rx_done", ok, 1);
        wait_fall(n, f);
        chk("ack_fall", f, 1);
        chk("ack_low", ps2_data_out, 0);
        k = 0;
        while (ps2_clock_out === 1'b0 && k < LIM) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        chk("rx_vcnt", n_rxv - v0, 1);
        chk("rx_ecnt", n_rxe - e0, 0);
        chk("rx_data", rx_data, 8'hED);
        chk("rx_rel", ps2_data_out, 1);
        get_frame(bits, gap, lmin, lmax, ok);
        chk("fa_done", ok, 1);
        chk("fa_bits", bits, 11'b11111110100);

        // Bad parity -> rx_error, no ACK, reply 0xFE.
        v0 = n_rxv;
        e0 = n_rxe;
        host_send(8'hED, 1'b0, ok);
        chk("err_done", ok, 1);
        seen = 1'b0;
        repeat (HB + 5) begin
            @(negedge clk);
            if (ps2_data_out === 1'b0) seen = 1'b1;
        end
        chk("err_noack", seen, 0);
        chk("err_ecnt", n_rxe - e0, 1);
        chk("err_vcnt", n_rxv - v0, 0);
        get_frame(bits, gap, lmin, lmax, ok);
        chk("fe_done", ok, 1);
        chk("fe_bits", bits, 11'b10111111100);

        // Back-to-back with tx_valid held high.
        @(negedge clk);
        tx_data  = 8'h12;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'hF0;
        get_frame(bits, gap, lmin, lmax, ok);
        chk("b1_done", ok, 1);
        chk("b1_bits", bits, 11'b11000100100);
        chk("b1_ready", tx_ready, 1);
        @(negedge clk);
        chk("b2_accept", tx_ready, 0);
        tx_valid = 1'b0;
        get_frame(bits, gap, lmin, lmax, ok);
        chk("b2_done", ok, 1);
        chk("b2_bits", bits, 11'b11111100000);
        chk("b2_gap", gap >= IC + HB - 1, 1);

        // Reset pulse in the middle of a low phase.
        send_byte(8'h55);
        for (int i = 0; i < 3; i++) wait_fall(n, f);
        chk("rs_reach", f, 1);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("rs_clk", ps2_clock_out, 1);
        chk("rs_dat", ps2_data_out, 1);
        chk("rs_ready", tx_ready, 1);
        chk("rs_busy", busy, 0);
        lows = 0;
        repeat (400) begin
            @(negedge clk);
            if (ps2_clock_out === 1'b0) lows++;
        end
        chk("rs_quiet", lows, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
